dmem_lsu: RTL and testbench

Load/store unit: the initiator for the word-wide data memory (`Data_Memory`). It accepts one load or store request at a time from the core. It translates RV32I `funct3` sizes (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the memory's `MemRW`/`addr`/`DataW`/`DataR` port. Sub-word stores use read-modify-write. Load data is returned sign- or zero-extended on a one-cycle response strobe.

---
 rtl/dmem_lsu_if.sv | 24 ++
 rtl/dmem_lsu.sv | 85 ++++++++
 tb/tb_dmem_lsu.sv | 108 ++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: core request/response and word-memory port of the load/store unit
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_MemRW;
  logic [31:0] mem_addr;
  logic [31:0] mem_DataW;
  logic [31:0] mem_DataR;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_DataR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_MemRW, mem_addr, mem_DataW
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_DataR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_MemRW, mem_addr, mem_DataW
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit driving a word-wide memory, sub-word stores via read-modify-write
module dmem_lsu #(
  parameter bit WORD_INDEX = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t      state, state_nx;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  ofs_q;
  logic [31:0] wd_q, rdata_q, addr_q, dataw_q;
  logic        err_q;
  logic        acc, illegal, misal, err_in;
  logic [31:0] waddr, lane, ld, mask, merged;
  logic [4:0]  sh;
  assign acc   = bus.req_valid & (state == IDLE);
  assign waddr = WORD_INDEX ? {2'b00, bus.req_addr[31:2]} : {bus.req_addr[31:2], 2'b00};
  always_comb begin
    illegal = bus.req_we ? (bus.req_funct3 > 3'd2)
                         : (bus.req_funct3 == 3'd3 || bus.req_funct3[2:1] == 2'b11);
    misal   = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
              (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'b00);
    err_in  = illegal | misal;
  end
  // Lane extraction for loads and lane merge for SB/SH both key off the latched byte offset
  always_comb begin
    sh     = {ofs_q, 3'b000};
    lane   = bus.mem_DataR >> sh;
    ld     = f3_q == 3'd0 ? {{24{lane[7]}}, lane[7:0]} :
             f3_q == 3'd1 ? {{16{lane[15]}}, lane[15:0]} :
             f3_q == 3'd4 ? {24'b0, lane[7:0]} :
             f3_q == 3'd5 ? {16'b0, lane[15:0]} : bus.mem_DataR;
    mask   = (f3_q[1:0] == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged = (bus.mem_DataR & ~mask) | ((wd_q << sh) & mask);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (!bus.req_valid ? IDLE :
                                err_in ? RESP :
                                (bus.req_we && bus.req_funct3 == 3'd2) ? WR : RD) :
               state == RD   ? (we_q ? WR : RESP) :
               state == WR   ? RESP : IDLE;
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    bus.mem_MemRW = state == WR;
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    bus.mem_addr  = addr_q;
    bus.mem_DataW = dataw_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      ofs_q   <= 2'd0;
      wd_q    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      dataw_q <= 32'd0;
    end else begin
      if (acc) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        ofs_q   <= bus.req_addr[1:0];
        wd_q    <= bus.req_wdata;
        rdata_q <= 32'd0;
        err_q   <= err_in;
        if (!err_in) addr_q <= waddr;
        if (!err_in && bus.req_we && bus.req_funct3 == 3'd2) dataw_q <= bus.req_wdata;
      end
      if (state == RD) begin
        if (we_q) dataw_q <= merged;
        else      rdata_q <= ld;
      end
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed checks of dmem_lsu against a small word memory model
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mem [0:63];
  dmem_lsu_if bus ();
  dmem_lsu #(.WORD_INDEX(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_DataR = mem[bus.mem_addr[5:0]];
  always @(posedge clk) if (bus.mem_MemRW) mem[bus.mem_addr[5:0]] <= bus.mem_DataW;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Issues one request, then checks response latency, data, error and write activity
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int lat,
                        input logic [31:0] rd, input logic er, input int wrs,
                        input logic [31:0] wa, input logic [31:0] wdat);
    int k = 0;
    int w = 0;
    logic [31:0] seen_a = 32'hx;
    logic [31:0] seen_d = 32'hx;
    @(negedge clk);
    chk({tag, ".ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 6 && k == 0; i++) begin
      @(negedge clk);
      if (bus.mem_MemRW) begin w++; seen_a = bus.mem_addr; seen_d = bus.mem_DataW; end
      if (bus.rsp_valid) begin
        k = i;
        chk({tag, ".rdata"}, bus.rsp_rdata, rd);
        chk({tag, ".err"}, {31'b0, bus.rsp_err}, {31'b0, er});
      end
    end
    chk({tag, ".lat"}, k, lat);
    chk({tag, ".wrs"}, w, wrs);
    if (wrs != 0) begin
      chk({tag, ".waddr"}, seen_a, wa);
      chk({tag, ".wdata"}, seen_d, wdat);
    end
  endtask
  initial begin
    int cnt;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst.rdata", bus.rsp_rdata, 32'd0);
    chk("rst.err", {31'b0, bus.rsp_err}, 32'd0);
    chk("rst.memrw", {31'b0, bus.mem_MemRW}, 32'd0);
    chk("rst.addr", bus.mem_addr, 32'd0);
    chk("rst.dataw", bus.mem_DataW, 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (3) begin @(negedge clk); if (bus.mem_MemRW) cnt++; end
    chk("idle.nowrite", cnt, 0);
    do_req("sw", 1'b1, 3'd2, 32'h44, 32'h1234_5678, 2, 32'd0, 1'b0, 1, 32'd17, 32'h1234_5678);
    chk("sw.mem", mem[17], 32'h1234_5678);
    do_req("lw", 1'b0, 3'd2, 32'h44, 32'd0, 2, 32'h1234_5678, 1'b0, 0, 32'd0, 32'd0);
    do_req("sb", 1'b1, 3'd0, 32'h45, 32'hFFFF_FFAB, 3, 32'd0, 1'b0, 1, 32'd17, 32'h1234_AB78);
    chk("sb.mem", mem[17], 32'h1234_AB78);
    do_req("sh", 1'b1, 3'd1, 32'h46, 32'h1111_BEEF, 3, 32'd0, 1'b0, 1, 32'd17, 32'hBEEF_AB78);
    chk("sh.mem", mem[17], 32'hBEEF_AB78);
    do_req("sw2", 1'b1, 3'd2, 32'h44, 32'h80FF_7F80, 2, 32'd0, 1'b0, 1, 32'd17, 32'h80FF_7F80);
    do_req("lb", 1'b0, 3'd0, 32'h44, 32'd0, 2, 32'hFFFF_FF80, 1'b0, 0, 32'd0, 32'd0);
    do_req("lbu", 1'b0, 3'd4, 32'h44, 32'd0, 2, 32'h0000_0080, 1'b0, 0, 32'd0, 32'd0);
    do_req("lh", 1'b0, 3'd1, 32'h46, 32'd0, 2, 32'hFFFF_80FF, 1'b0, 0, 32'd0, 32'd0);
    do_req("lhu", 1'b0, 3'd5, 32'h46, 32'd0, 2, 32'h0000_80FF, 1'b0, 0, 32'd0, 32'd0);
    do_req("lb3", 1'b0, 3'd0, 32'h47, 32'd0, 2, 32'hFFFF_FF80, 1'b0, 0, 32'd0, 32'd0);
    do_req("e.lw45", 1'b0, 3'd2, 32'h45, 32'd0, 1, 32'd0, 1'b1, 0, 32'd0, 32'd0);
    do_req("e.sh47", 1'b1, 3'd1, 32'h47, 32'hFFFF, 1, 32'd0, 1'b1, 0, 32'd0, 32'd0);
    do_req("e.ld011", 1'b0, 3'd3, 32'h44, 32'd0, 1, 32'd0, 1'b1, 0, 32'd0, 32'd0);
    do_req("e.st100", 1'b1, 3'd4, 32'h44, 32'd0, 1, 32'd0, 1'b1, 0, 32'd0, 32'd0);
    chk("e.mem", mem[17], 32'h80FF_7F80);
    do_req("sw16", 1'b1, 3'd2, 32'h40, 32'h0A0B_0C0D, 2, 32'd0, 1'b0, 1, 32'd16, 32'h0A0B_0C0D);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h0000_00CD;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid.inwr", {31'b0, bus.mem_MemRW}, 32'd1);
    rst_n = 1'b0;
    #1 chk("mid.memrw", {31'b0, bus.mem_MemRW}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin @(negedge clk); if (bus.rsp_valid) cnt++; end
    chk("mid.norsp", cnt, 0);
    chk("mid.mem", mem[16], 32'h0A0B_0C0D);
    chk("mid.ready", {31'b0, bus.req_ready}, 32'd1);
    do_req("lw16", 1'b0, 3'd2, 32'h40, 32'd0, 2, 32'h0A0B_0C0D, 1'b0, 0, 32'd0, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
